// File: rtl/wb_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_pkg
// Purpose  : Shared widths, reset level, trace record layout and the GPR
//            bypass-read helper used by the writeback commit unit.
// Revision : 1.0 - initial release
// ============================================================================
package wb_commit_pkg;

  localparam int          GPR_BUS             = 32;
  localparam int          GPR_ADDR_BUS        = 5;
  localparam logic        RST_ENABLE          = 1'b1;
  localparam int          TRACE_DEPTH_DEFAULT = 4;
  localparam int          TRACE_REC_W         = 73;
  localparam logic [3:0]  TRACE_WEN_ALL       = 4'hF;

  // One retired register write as seen by the difftest/trace logger.
  typedef struct packed {
    logic [31:0]             pc;
    logic [3:0]              wen;
    logic [GPR_ADDR_BUS-1:0] wnum;
    logic [GPR_BUS-1:0]      wdata;
  } trace_rec_t;

  // GPR read with $0 forced to zero and same-cycle writeback bypass.
  function automatic logic [GPR_BUS-1:0] gpr_bypass_read(
    input logic [GPR_ADDR_BUS-1:0] raddr,
    input logic                    wen,
    input logic [GPR_ADDR_BUS-1:0] waddr,
    input logic [GPR_BUS-1:0]      wdata,
    input logic [GPR_BUS-1:0]      stored
  );
    if (raddr == '0) begin
      return '0;
    end else if (wen && (waddr == raddr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_commit_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_if
// Purpose  : Bundle of MEM/WB writeback inputs, ID read ports, HI/LO view,
//            trace sink handshake and status counters of wb_commit.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_commit_if #(
  parameter int DROP_CNT_W = 16
);
  import wb_commit_pkg::*;

  logic                    wb_regfile_write_enable;
  logic [GPR_ADDR_BUS-1:0] wb_regfile_write_addr;
  logic [GPR_BUS-1:0]      wb_regfile_write_data;
  logic                    wb_hi_write_enable;
  logic                    wb_lo_write_enable;
  logic [GPR_BUS-1:0]      wb_hi_write_data;
  logic [GPR_BUS-1:0]      wb_lo_write_data;
  logic [31:0]             wb_pc;
  logic                    wb_commit_valid;
  logic [GPR_ADDR_BUS-1:0] rs_addr;
  logic [GPR_ADDR_BUS-1:0] rt_addr;
  logic [GPR_BUS-1:0]      rs_data;
  logic [GPR_BUS-1:0]      rt_data;
  logic [GPR_BUS-1:0]      hi_data;
  logic [GPR_BUS-1:0]      lo_data;
  logic                    trace_valid;
  logic                    trace_ready;
  logic [31:0]             trace_pc;
  logic [3:0]              trace_wen;
  logic [GPR_ADDR_BUS-1:0] trace_wnum;
  logic [GPR_BUS-1:0]      trace_wdata;
  logic [31:0]             retire_count;
  logic [DROP_CNT_W-1:0]   trace_drop_count;

  // Pipeline / ID / trace-sink side.
  modport master (
    output wb_regfile_write_enable, wb_regfile_write_addr, wb_regfile_write_data,
    output wb_hi_write_enable, wb_lo_write_enable, wb_hi_write_data, wb_lo_write_data,
    output wb_pc, wb_commit_valid, rs_addr, rt_addr, trace_ready,
    input  rs_data, rt_data, hi_data, lo_data,
    input  trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata,
    input  retire_count, trace_drop_count
  );

  // Commit unit side.
  modport slave (
    input  wb_regfile_write_enable, wb_regfile_write_addr, wb_regfile_write_data,
    input  wb_hi_write_enable, wb_lo_write_enable, wb_hi_write_data, wb_lo_write_data,
    input  wb_pc, wb_commit_valid, rs_addr, rt_addr, trace_ready,
    output rs_data, rt_data, hi_data, lo_data,
    output trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata,
    output retire_count, trace_drop_count
  );

endinterface
`default_nettype wire

// File: rtl/wb_commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_trace_fifo
// Purpose  : Synchronous FIFO, push/full on the write side, valid/ready on
//            the read side. A push into a full FIFO is accepted only when a
//            pop happens in the same cycle. Head output is zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 73
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] din_i,
  output logic                  full_o,
  output logic                  valid_o,
  input  wire logic             ready_i,
  output logic [WIDTH-1:0]      dout_o
);
  import wb_commit_pkg::*;

  // Extra pointer bit separates the full and empty cases.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Occupancy flags and accepted push/pop for this cycle.
  always_comb begin
    w_empty  = (wr_ptr_q == rd_ptr_q);
    w_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    w_pop    = !w_empty && ready_i;
    w_push   = push_i && (!w_full || w_pop);
    wr_ptr_d = w_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = w_pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
  end

  // Pointer registers; clearing them discards every queued record at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are never observed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  assign full_o  = w_full;
  assign valid_o = !w_empty;
  assign dout_o  = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit
// Purpose  : Writeback commit unit. Holds the GPR file, HI/LO, the retired
//            instruction counter and a commit-trace FIFO with a saturating
//            drop counter. Reads bypass the same-cycle writeback.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEFAULT,
  parameter int DROP_CNT_W  = 16
) (
  input wire logic   clk,
  input wire logic   rst,
  wb_commit_if.slave bus
);

  logic [GPR_BUS-1:0]    gpr_q [32];
  logic [GPR_BUS-1:0]    hi_q, hi_d;
  logic [GPR_BUS-1:0]    lo_q, lo_d;
  logic [31:0]           retire_q, retire_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  w_gpr_we;
  logic                  w_push_req;
  logic                  w_fifo_full;
  logic                  w_fifo_valid;
  logic                  w_pop;
  logic                  w_drop;
  trace_rec_t            w_push_rec;
  trace_rec_t            w_head_rec;

  // Writeback decode: $0 is never written and never traced.
  always_comb begin
    w_gpr_we   = bus.wb_regfile_write_enable && (bus.wb_regfile_write_addr != '0);
    w_push_req = bus.wb_commit_valid && w_gpr_we;
    w_push_rec = '{pc:    bus.wb_pc,
                   wen:   TRACE_WEN_ALL,
                   wnum:  bus.wb_regfile_write_addr,
                   wdata: bus.wb_regfile_write_data};
    w_pop      = w_fifo_valid && bus.trace_ready;
    w_drop     = w_push_req && w_fifo_full && !w_pop;
  end

  // Next-state for HI/LO, the retire counter and the saturating drop counter.
  always_comb begin
    hi_d     = bus.wb_hi_write_enable ? bus.wb_hi_write_data : hi_q;
    lo_d     = bus.wb_lo_write_enable ? bus.wb_lo_write_data : lo_q;
    retire_d = bus.wb_commit_valid ? (retire_q + 32'd1) : retire_q;
    drop_d   = drop_q;
    if (w_drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  // General-purpose register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (w_gpr_we) begin
      gpr_q[bus.wb_regfile_write_addr] <= bus.wb_regfile_write_data;
    end
  end

  // HI/LO and status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      hi_q     <= '0;
      lo_q     <= '0;
      retire_q <= '0;
      drop_q   <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      retire_q <= retire_d;
      drop_q   <= drop_d;
    end
  end

  // Read ports with same-cycle bypass of the incoming writeback.
  always_comb begin
    bus.rs_data = gpr_bypass_read(bus.rs_addr, bus.wb_regfile_write_enable,
                                  bus.wb_regfile_write_addr,
                                  bus.wb_regfile_write_data, gpr_q[bus.rs_addr]);
    bus.rt_data = gpr_bypass_read(bus.rt_addr, bus.wb_regfile_write_enable,
                                  bus.wb_regfile_write_addr,
                                  bus.wb_regfile_write_data, gpr_q[bus.rt_addr]);
    bus.hi_data = bus.wb_hi_write_enable ? bus.wb_hi_write_data : hi_q;
    bus.lo_data = bus.wb_lo_write_enable ? bus.wb_lo_write_data : lo_q;
  end

  // Trace FIFO; the head is registered, so no wb_* input reaches trace_*.
  wb_commit_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TRACE_REC_W)
  ) u_trace_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push_req),
    .din_i   (w_push_rec),
    .full_o  (w_fifo_full),
    .valid_o (w_fifo_valid),
    .ready_i (bus.trace_ready),
    .dout_o  (w_head_rec)
  );

  assign bus.trace_valid      = w_fifo_valid;
  assign bus.trace_pc         = w_head_rec.pc;
  assign bus.trace_wen        = w_head_rec.wen;
  assign bus.trace_wnum       = w_head_rec.wnum;
  assign bus.trace_wdata      = w_head_rec.wdata;
  assign bus.retire_count     = retire_q;
  assign bus.trace_drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit
// Purpose  : Self-checking bench for wb_commit: directed scenarios followed by
//            random traffic, with a reference model and a trace scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit;

  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_commit_if #(.DROP_CNT_W(DW)) bus ();

  wb_commit #(.TRACE_DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0]   gpr_m [32];
  logic [31:0]   hi_m, lo_m, ret_m;
  logic [DW-1:0] drop_m;
  int            occ_m;
  logic [72:0]   exp_q [$];
  logic [31:0]   pc_r;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) gpr_m[i] = '0;
    hi_m = '0; lo_m = '0; ret_m = '0; drop_m = '0; occ_m = 0;
    exp_q.delete();
  endtask

  task automatic idle();
    bus.wb_regfile_write_enable = 1'b0;
    bus.wb_regfile_write_addr   = '0;
    bus.wb_regfile_write_data   = '0;
    bus.wb_hi_write_enable      = 1'b0;
    bus.wb_lo_write_enable      = 1'b0;
    bus.wb_hi_write_data        = '0;
    bus.wb_lo_write_data        = '0;
    bus.wb_commit_valid         = 1'b0;
  endtask

  task automatic commit_write(input logic [4:0] a, input logic [31:0] d);
    pc_r += 32'd4;
    bus.wb_pc                   = pc_r;
    bus.wb_regfile_write_enable = 1'b1;
    bus.wb_regfile_write_addr   = a;
    bus.wb_regfile_write_data   = d;
    bus.wb_commit_valid         = 1'b1;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    if (ra == 0) return 32'd0;
    if (bus.wb_regfile_write_enable && bus.wb_regfile_write_addr == ra)
      return bus.wb_regfile_write_data;
    return gpr_m[ra];
  endfunction

  // One cycle: check combinational/state outputs, then advance the model on the edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    chk("rs_data", 73'(bus.rs_data), 73'(exp_read(bus.rs_addr)));
    chk("rt_data", 73'(bus.rt_data), 73'(exp_read(bus.rt_addr)));
    chk("hi_data", 73'(bus.hi_data), 73'(bus.wb_hi_write_enable ? bus.wb_hi_write_data : hi_m));
    chk("lo_data", 73'(bus.lo_data), 73'(bus.wb_lo_write_enable ? bus.wb_lo_write_data : lo_m));
    chk("trace_valid", 73'(bus.trace_valid), 73'(occ_m > 0));
    chk("retire_count", 73'(bus.retire_count), 73'(ret_m));
    chk("drop_count", 73'(bus.trace_drop_count), 73'(drop_m));
    if (occ_m == 0)
      chk("empty_head", {bus.trace_pc, bus.trace_wen, bus.trace_wnum, bus.trace_wdata}, 73'd0);
    @(posedge clk);
    pop = (occ_m > 0) && bus.trace_ready;
    if (bus.wb_regfile_write_enable && bus.wb_regfile_write_addr != 0) begin
      if (bus.wb_commit_valid) begin
        if (occ_m == DEPTH && !pop) begin
          if (drop_m != '1) drop_m = drop_m + 1'b1;
        end else begin
          exp_q.push_back({bus.wb_pc, 4'hF, bus.wb_regfile_write_addr, bus.wb_regfile_write_data});
          occ_m++;
        end
      end
      gpr_m[bus.wb_regfile_write_addr] = bus.wb_regfile_write_data;
    end
    if (pop) occ_m--;
    if (bus.wb_hi_write_enable) hi_m = bus.wb_hi_write_data;
    if (bus.wb_lo_write_enable) lo_m = bus.wb_lo_write_data;
    if (bus.wb_commit_valid) ret_m = ret_m + 32'd1;
    #1;
  endtask

  // Scoreboard monitor: compares the presented head record with the oldest expected one.
  always @(negedge clk) begin
    if (!rst && bus.trace_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trace_unexpected: got pc=%h wnum=%0d, expected no record", bus.trace_pc, bus.trace_wnum);
      end else begin
        chk("trace_record", {bus.trace_pc, bus.trace_wen, bus.trace_wnum, bus.trace_wdata}, exp_q[0]);
        if (bus.trace_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    bus.wb_pc = 32'hBFC0_0000;
    bus.rs_addr = 5'd1;
    bus.rt_addr = 5'd2;
    bus.trace_ready = 1'b1;
    pc_r = 32'hBFC0_0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Bypass then storage read of $5.
    commit_write(5'd5, 32'h1234_5678);
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd0;
    step();
    idle();
    step();
    chk("rs_stored", 73'(bus.rs_data), 73'h1234_5678);

    // Writes to $0 are ignored and not traced.
    commit_write(5'd0, 32'hFFFF_FFFF);
    bus.rs_addr = 5'd0;
    step();
    idle();
    step();

    // HI and LO in the same cycle.
    bus.wb_hi_write_enable = 1'b1; bus.wb_hi_write_data = 32'hA;
    bus.wb_lo_write_enable = 1'b1; bus.wb_lo_write_data = 32'hB;
    step();
    idle();
    step();
    chk("hi_held", 73'(bus.hi_data), 73'hA);
    chk("lo_held", 73'(bus.lo_data), 73'hB);
    repeat (3) step();

    // Five commits into a stalled sink: four held, one dropped.
    bus.trace_ready = 1'b0;
    pc_r = 32'hBFC0_0000;
    for (int i = 0; i < 5; i++) begin
      commit_write(5'(i + 1), $urandom);
      bus.rs_addr = 5'(i + 1);
      step();
    end
    idle();
    step();
    chk("drop_after_five", 73'(bus.trace_drop_count), 73'd1);
    chk("head_pc_first", 73'(bus.trace_pc), 73'hBFC0_0004);
    bus.trace_ready = 1'b1;
    repeat (5) step();

    // Full FIFO with simultaneous push and pop: no drop.
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      commit_write(5'(10 + i), $urandom);
      step();
    end
    bus.trace_ready = 1'b1;
    commit_write(5'd20, 32'hCAFE_F00D);
    step();
    idle();
    bus.trace_ready = 1'b0;
    repeat (2) step();
    chk("drop_full_pushpop", 73'(bus.trace_drop_count), 73'd1);
    bus.trace_ready = 1'b1;
    repeat (5) step();

    // Async reset while three records are queued.
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      commit_write(5'(1 + i), $urandom);
      step();
    end
    idle();
    bus.rs_addr = 5'd1;
    #2 rst = 1'b1;
    #1;
    chk("rst_trace_valid", 73'(bus.trace_valid), 73'd0);
    chk("rst_retire", 73'(bus.retire_count), 73'd0);
    chk("rst_drop", 73'(bus.trace_drop_count), 73'd0);
    chk("rst_gpr", 73'(bus.rs_data), 73'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    bus.trace_ready = 1'b1;

    // 100 commit pulses without register writes.
    for (int i = 0; i < 100; i++) begin
      idle();
      bus.wb_commit_valid = 1'b1;
      step();
    end
    idle();
    step();
    chk("retire_100", 73'(bus.retire_count), 73'd100);
    chk("no_records", 73'(bus.trace_valid), 73'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      pc_r += 32'd4;
      bus.wb_pc                   = pc_r;
      bus.wb_regfile_write_enable = 1'($urandom_range(0, 1));
      bus.wb_regfile_write_addr   = 5'($urandom_range(0, 31));
      bus.wb_regfile_write_data   = $urandom;
      bus.wb_commit_valid         = ($urandom_range(0, 3) != 0);
      bus.wb_hi_write_enable      = 1'($urandom_range(0, 1));
      bus.wb_hi_write_data        = $urandom;
      bus.wb_lo_write_enable      = 1'($urandom_range(0, 1));
      bus.wb_lo_write_data        = $urandom;
      bus.trace_ready             = ($urandom_range(0, 2) != 0);
      bus.rs_addr = ($urandom_range(0, 2) == 0) ? bus.wb_regfile_write_addr : 5'($urandom_range(0, 31));
      bus.rt_addr = ($urandom_range(0, 2) == 0) ? bus.wb_regfile_write_addr : 5'($urandom_range(0, 31));
      step();
    end
    idle();
    bus.trace_ready = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_commit.md
# wb_commit

Writeback commit unit: the consuming end of the MEM/WB pipeline register. It owns the 32×32 general-purpose register file, HI and LO, and a commit-trace FIFO for the difftest/trace logger. Each cycle it applies the registered writeback bundle and serves ID-stage register reads with same-cycle write bypass. Every retired register write is queued as a trace record.

## Interface
Parameters:
- TRACE_DEPTH, 4, trace FIFO entries; power of two, ≥2.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_regfile_write_enable  in  1  GPR write request.
- wb_regfile_write_addr  in  5  GPR destination.
- wb_regfile_write_data  in  32  GPR write data.
- wb_hi_write_enable / wb_lo_write_enable  in  1 each  HI/LO write requests.
- wb_hi_write_data / wb_lo_write_data  in  32 each  HI/LO data.
- wb_pc  in  32  PC of the instruction in WB.
- wb_commit_valid  in  1  one-cycle pulse per retired instruction; low on bubbles and stall-held cycles.
- rs_addr, rt_addr  in  5 each  ID read addresses.
- rs_data, rt_data  out  32 each  read data (combinational).
- hi_data, lo_data  out  32 each  current HI/LO (combinational, bypassed).
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  sink accepts head.
- trace_pc  out  32; trace_wen  out  4; trace_wnum  out  5; trace_wdata  out  32  head record.
- retire_count  out  32  retired-instruction counter.
- trace_drop_count  out  DROP_CNT_W  records lost to a full FIFO.

## Operation
- GPR write: on posedge, when wb_regfile_write_enable=1 and addr≠0, reg[addr] ← data. Writes to $0 are ignored. Repeated writes during held cycles are harmless.
- GPR read:
  - addr=0 → 0.
  - Otherwise, if a GPR write is active and its addr equals the read addr → wb_regfile_write_data (bypass).
  - Otherwise → stored value.
  - rs and rt are independent.
- HI/LO: each register is written independently on its enable. hi_data/lo_data bypass the incoming data while the matching enable is high.
- Trace push condition: wb_commit_valid & wb_regfile_write_enable & (wb_regfile_write_addr≠0).
- Trace record contents: {wb_pc, 4'hF, addr, data}.
- Trace pop: trace_valid & trace_ready.
- Full, push with no pop: record dropped; trace_drop_count increments and saturates at all-ones.
- Full, push and pop in the same cycle: both occur, no drop, occupancy unchanged.
- Empty, push and pop in the same cycle: pop impossible (trace_valid=0); push proceeds.
- Sink handshake: trace_* head fields stay stable while trace_valid=1 and trace_ready=0.
- retire_count increments on every wb_commit_valid pulse and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - All GPRs, HI, LO, retire_count and trace_drop_count cleared to 0.
  - FIFO emptied; trace_valid=0; trace_* fields 0.
  - Reset asserted mid-operation discards queued records immediately.
- Write-to-read latency is 0 cycles via bypass; the stored value is visible from the next cycle.
- Trace latency: a record pushed at edge N gives trace_valid=1 after edge N with no combinational path from wb_* to trace_*. Throughput is one record per cycle.
- Pointers are log2(TRACE_DEPTH)+1 bits wide so full and empty are distinguishable.

## Structure
- Shared defines: GPR_BUS, GPR_ADDR_BUS, RST_ENABLE, plus new TRACE_DEPTH_DEFAULT and TRACE_REC_W (73).
- Sub-module: trace_fifo (parameterised synchronous FIFO with valid/ready pop and push/full). Drop counting stays in wb_commit.
- Register file, HI/LO and counters are inline.

## Test plan
- Reset, then write $5←0x1234_5678 with rs_addr=5 in the same cycle → rs_data=0x12345678 via bypass; next cycle reads the same value from storage; rt_addr=0 → 0.
- Write $0←0xFFFF_FFFF → rs_addr=0 returns 0 in the same cycle and all later cycles; no trace record is pushed.
- HI and LO written in the same cycle with 0xA, 0xB → hi_data=0xA, lo_data=0xB in that cycle and held afterwards.
- trace_ready=0, five committing writes with TRACE_DEPTH=4 → four records held, trace_drop_count=1. Raise trace_ready → records pop in order with PCs 0xBFC0_0000 +4, +8, … and trace_wen=4'hF.
- FIFO full, push and pop in the same cycle → no drop, occupancy stays 4. 100 commit pulses with no writes → retire_count=100, no records.
- Assert rst while the FIFO holds 3 records → trace_valid drops immediately and all counters read 0.
